// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: state encoding, owner ids, default widths.
package memory_bus_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BURST_CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_ACC  = 3'd1,
        ST_CPU_RESP = 3'd2,
        ST_DMA_ACC  = 3'd3,
        ST_DMA_RESP = 3'd4
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // DMA wins an IDLE arbitration if locked, alone, or the CPU was served last.
    function automatic logic dma_wins(input logic lock_active, input logic cpu_req,
                                      input logic dma_req, input logic last_owner);
        return dma_req & (lock_active | ~cpu_req | (last_owner == OWNER_CPU));
    endfunction

endpackage

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing a single-port memory between the CPU and a DMA requester,
// with a bounded DMA burst lock and a one-cycle done pulse per access.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_grant,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_lock,
    input  logic                  dma_write,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_grant,
    output logic                  dma_done,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  memory_read,
    output logic                  memory_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e             state_q, state_d;
    logic                   last_owner_q, last_owner_d;
    logic                   lock_active_q, lock_active_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]  dma_rdata_q, dma_rdata_d;
    logic                   grant_dma;
    logic                   burst_more;

    // State and datapath registers; reset aborts any in-flight access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_owner_q  <= OWNER_DMA;
            lock_active_q <= 1'b0;
            burst_cnt_q   <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            lock_active_q <= lock_active_d;
            burst_cnt_q   <= burst_cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
        end
    end

    // Next-state: arbitration, request latching, read capture and burst-lock bookkeeping.
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        lock_active_d = lock_active_q;
        burst_cnt_d   = burst_cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        grant_dma     = dma_wins(lock_active_q, cpu_req, dma_req, last_owner_q);
        burst_more    = (5'(burst_cnt_q) + 5'd1) < 5'(MAX_BURST);

        case (state_q)
            ST_IDLE: begin
                // A lock whose owner went quiet is released before arbitrating.
                if (lock_active_q && !dma_req) begin
                    lock_active_d = 1'b0;
                    burst_cnt_d   = '0;
                end
                if (grant_dma) begin
                    state_d = ST_DMA_ACC;
                    addr_d  = dma_addr;
                    wdata_d = dma_wdata;
                    write_d = dma_write;
                end else if (cpu_req) begin
                    state_d = ST_CPU_ACC;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    write_d = cpu_write;
                end
            end
            ST_CPU_ACC: begin
                state_d = ST_CPU_RESP;
                if (!write_q) begin
                    cpu_rdata_d = mem_rdata;
                end
            end
            ST_CPU_RESP: begin
                state_d      = ST_IDLE;
                last_owner_d = OWNER_CPU;
            end
            ST_DMA_ACC: begin
                state_d = ST_DMA_RESP;
                if (!write_q) begin
                    dma_rdata_d = mem_rdata;
                end
            end
            ST_DMA_RESP: begin
                state_d      = ST_IDLE;
                last_owner_d = OWNER_DMA;
                if (dma_lock && burst_more) begin
                    lock_active_d = 1'b1;
                    burst_cnt_d   = burst_cnt_q + BURST_CNT_W'(1);
                end else begin
                    lock_active_d = 1'b0;
                    burst_cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decodes of registered state and latched request fields.
    assign cpu_grant    = (state_q == ST_CPU_ACC) || (state_q == ST_CPU_RESP);
    assign dma_grant    = (state_q == ST_DMA_ACC) || (state_q == ST_DMA_RESP);
    assign cpu_done     = (state_q == ST_CPU_RESP);
    assign dma_done     = (state_q == ST_DMA_RESP);
    assign memory_read  = ((state_q == ST_CPU_ACC) || (state_q == ST_DMA_ACC)) && !write_q;
    assign memory_write = ((state_q == ST_CPU_ACC) || (state_q == ST_DMA_ACC)) && write_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dma_rdata    = dma_rdata_q;
    assign cpu_stall    = cpu_req && !cpu_done;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: vector table, scoreboard and hand sequences.
module tb_memory_bus_arbiter;

    typedef struct {
        logic       dma;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_write;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_grant, cpu_done, cpu_stall;
    logic       dma_req, dma_lock, dma_write;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       dma_grant, dma_done;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       memory_read, memory_write;

    logic [7:0] mem [256];
    vec_t       cpu_q[$];
    vec_t       dma_q[$];
    int         log_owner[$];
    int         log_cyc[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    memory_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_grant(dma_grant), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .memory_read(memory_read),
        .memory_write(memory_write), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Memory model plus scoreboard: strobes checked against the owner's pending entry, done pops it.
    task automatic monitor();
        vec_t e;
        forever begin
            @(negedge clock);
            if (memory_read || memory_write) begin
                check("sb_strobe_owner", 32'(cpu_grant ^ dma_grant), 1);
                if (cpu_grant && cpu_q.size() != 0) begin
                    e = cpu_q[0];
                    check("sb_cpu_addr", 32'(mem_addr), 32'(e.addr));
                    check("sb_cpu_dir", 32'(memory_write), 32'(e.wr));
                end
                if (dma_grant && dma_q.size() != 0) begin
                    e = dma_q[0];
                    check("sb_dma_addr", 32'(mem_addr), 32'(e.addr));
                    check("sb_dma_dir", 32'(memory_write), 32'(e.wr));
                end
                if (memory_write) mem[mem_addr] = mem_wdata;
            end
            if (cpu_done) begin
                if (cpu_q.size() == 0) check("sb_cpu_unexpected_done", 1, 0);
                else begin
                    e = cpu_q.pop_front();
                    check("sb_cpu_rdata", 32'(cpu_rdata), 32'(e.exp_rd));
                end
            end
            if (dma_done) begin
                if (dma_q.size() == 0) check("sb_dma_unexpected_done", 1, 0);
                else begin
                    e = dma_q.pop_front();
                    check("sb_dma_rdata", 32'(dma_rdata), 32'(e.exp_rd));
                end
            end
        end
    endtask

    // One uncontended access with cycle-exact checks at N, N+1, N+2 and the following IDLE.
    task automatic do_access(input vec_t v);
        if (v.dma) dma_q.push_back(v); else cpu_q.push_back(v);
        if (v.dma) begin
            dma_req = 1'b1; dma_write = v.wr; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        #1;
        check("req_stall", 32'(cpu_stall), v.dma ? 0 : 1);
        @(posedge clock); #1;
        check("acc_grant", 32'(v.dma ? dma_grant : cpu_grant), 1);
        check("acc_other_grant", 32'(v.dma ? cpu_grant : dma_grant), 0);
        check("acc_read", 32'(memory_read), 32'(!v.wr));
        check("acc_write", 32'(memory_write), 32'(v.wr));
        if (v.dma) begin
            dma_addr = ~v.addr; dma_wdata = ~v.wdata;
        end else begin
            cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
        end
        #1;
        check("acc_addr", 32'(mem_addr), 32'(v.addr));
        if (v.wr) check("acc_wdata", 32'(mem_wdata), 32'(v.wdata));
        @(posedge clock); #1;
        check("resp_done", 32'(v.dma ? dma_done : cpu_done), 1);
        check("resp_rdata", 32'(v.dma ? dma_rdata : cpu_rdata), 32'(v.exp_rd));
        check("resp_strobes", 32'({memory_read, memory_write}), 0);
        check("resp_stall", 32'(cpu_stall), 0);
        cpu_req = 1'b0; dma_req = 1'b0;
        @(posedge clock); #1;
        check("idle_done", 32'({cpu_done, dma_done}), 0);
        check("idle_grant", 32'({cpu_grant, dma_grant}), 0);
    endtask

    // Log done pulses until target reached or budget expires; drops both requests on the last done.
    task automatic wait_dones(input int target, input int budget);
        int cyc = 0;
        int cnt = 0;
        log_owner.delete();
        log_cyc.delete();
        while (cnt < target && cyc < budget) begin
            @(posedge clock); #1;
            cyc++;
            if (cpu_done) begin log_owner.push_back(0); log_cyc.push_back(cyc); cnt++; end
            if (dma_done) begin log_owner.push_back(1); log_cyc.push_back(cyc); cnt++; end
            if (cnt >= target) begin cpu_req = 1'b0; dma_req = 1'b0; end
        end
        check("done_count", 32'(cnt), 32'(target));
    endtask

    initial begin
        vec_t vecs [10];
        vec_t e;
        int   exp_burst [5];
        int   exp_alt [4];

        vecs[0] = '{dma:1'b0, wr:1'b0, addr:8'h10, wdata:8'h00, exp_rd:8'h5A};
        vecs[1] = '{dma:1'b1, wr:1'b1, addr:8'h20, wdata:8'hC3, exp_rd:8'h00};
        vecs[2] = '{dma:1'b1, wr:1'b0, addr:8'h20, wdata:8'h00, exp_rd:8'hC3};
        vecs[3] = '{dma:1'b0, wr:1'b1, addr:8'h44, wdata:8'h99, exp_rd:8'h5A};
        vecs[4] = '{dma:1'b0, wr:1'b0, addr:8'h44, wdata:8'h00, exp_rd:8'h99};
        vecs[5] = '{dma:1'b1, wr:1'b0, addr:8'hF0, wdata:8'h00, exp_rd:8'h0F};
        vecs[6] = '{dma:1'b1, wr:1'b1, addr:8'h10, wdata:8'h77, exp_rd:8'h0F};
        vecs[7] = '{dma:1'b0, wr:1'b0, addr:8'h10, wdata:8'h00, exp_rd:8'h77};
        vecs[8] = '{dma:1'b0, wr:1'b0, addr:8'h00, wdata:8'h00, exp_rd:8'hFF};
        vecs[9] = '{dma:1'b1, wr:1'b0, addr:8'h01, wdata:8'h00, exp_rd:8'hFE};
        exp_alt   = '{0, 1, 0, 1};
        exp_burst = '{1, 1, 1, 1, 0};

        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        mem[8'h10] = 8'h5A;

        reset = 1'b0;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_write = 1'b0; dma_addr = '0; dma_wdata = '0;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("rst_ctrl", 32'({cpu_grant, dma_grant, cpu_done, dma_done, memory_read, memory_write}), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 0);
        check("rst_stall", 32'(cpu_stall), 0);

        // Reset asserted during CPU_ACC aborts the read; CPU wins again after release.
        reset = 1'b1;
        e = '{dma:1'b0, wr:1'b0, addr:8'h33, wdata:8'h00, exp_rd:8'hCC};
        cpu_q.push_back(e);
        cpu_req = 1'b1; cpu_addr = 8'h33;
        @(posedge clock); #1;
        check("abort_acc_read", 32'(memory_read), 1);
        reset = 1'b0;
        @(posedge clock); #1;
        check("abort_read_off", 32'(memory_read), 0);
        check("abort_grant_off", 32'(cpu_grant), 0);
        check("abort_rdata_clear", 32'(cpu_rdata), 0);
        @(posedge clock); #1;
        check("abort_no_done", 32'({cpu_done, dma_done}), 0);
        check("abort_outs", 32'({mem_addr, memory_read, memory_write}), 0);
        reset = 1'b1;
        cpu_q.delete();
        cpu_q.push_back(e);
        @(posedge clock); #1;
        check("release_cpu_grant", 32'(cpu_grant), 1);
        check("release_dma_grant", 32'(dma_grant), 0);
        @(posedge clock); #1;
        check("release_done", 32'(cpu_done), 1);
        check("release_rdata", 32'(cpu_rdata), 32'(8'hCC));
        cpu_req = 1'b0;
        @(posedge clock); #1;

        // Table-driven single accesses.
        for (int i = 0; i < 10; i++) do_access(vecs[i]);

        // Both requesting continuously: strict alternation, 3 cycles per access.
        cpu_q.push_back('{dma:1'b0, wr:1'b0, addr:8'h10, wdata:8'h00, exp_rd:8'h77});
        cpu_q.push_back('{dma:1'b0, wr:1'b0, addr:8'h10, wdata:8'h00, exp_rd:8'h77});
        dma_q.push_back('{dma:1'b1, wr:1'b0, addr:8'h20, wdata:8'h00, exp_rd:8'hC3});
        dma_q.push_back('{dma:1'b1, wr:1'b0, addr:8'h20, wdata:8'h00, exp_rd:8'hC3});
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h10;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 8'h20; dma_lock = 1'b0;
        wait_dones(4, 40);
        for (int i = 0; i < log_owner.size() && i < 4; i++) begin
            check($sformatf("alt_owner_%0d", i), 32'(log_owner[i]), 32'(exp_alt[i]));
            check($sformatf("alt_cycle_%0d", i), 32'(log_cyc[i]), 32'(2 + 3 * i));
        end
        @(posedge clock); #1;

        // Locked DMA burst against a waiting CPU: exactly four DMA accesses, then the CPU.
        for (int i = 0; i < 4; i++)
            dma_q.push_back('{dma:1'b1, wr:1'b0, addr:8'h01, wdata:8'h00, exp_rd:8'hFE});
        cpu_q.push_back('{dma:1'b0, wr:1'b0, addr:8'h00, wdata:8'h00, exp_rd:8'hFF});
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 8'h01;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_addr = 8'h00;
        wait_dones(5, 60);
        for (int i = 0; i < log_owner.size() && i < 5; i++)
            check($sformatf("burst_owner_%0d", i), 32'(log_owner[i]), 32'(exp_burst[i]));
        check("burst_lock_cleared", 32'(dut.lock_active_q), 0);
        check("burst_cnt_cleared", 32'(dut.burst_cnt_q), 0);
        dma_lock = 1'b0;
        @(posedge clock); #1;

        // Locked DMA goes quiet in IDLE: lock released and CPU granted from that same IDLE cycle.
        dma_q.push_back('{dma:1'b1, wr:1'b0, addr:8'h20, wdata:8'h00, exp_rd:8'hC3});
        cpu_q.push_back('{dma:1'b0, wr:1'b0, addr:8'h44, wdata:8'h00, exp_rd:8'h99});
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 8'h20;
        wait_dones(1, 10);
        cpu_req = 1'b1; cpu_addr = 8'h44;
        @(posedge clock); #1;
        check("drop_lock_set", 32'(dut.lock_active_q), 1);
        check("drop_burst_one", 32'(dut.burst_cnt_q), 1);
        check("drop_idle_grant", 32'({cpu_grant, dma_grant}), 0);
        dma_lock = 1'b0;
        @(posedge clock); #1;
        check("drop_cpu_grant", 32'(cpu_grant), 1);
        check("drop_lock_clear", 32'(dut.lock_active_q), 0);
        check("drop_burst_clear", 32'(dut.burst_cnt_q), 0);
        wait_dones(1, 10);
        repeat (2) @(posedge clock);
        #1;

        check("cpu_queue_empty", 32'(cpu_q.size()), 0);
        check("dma_queue_empty", 32'(dma_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the single-port program/data memory between the CPU control path (fetch, operand read, store) and a DMA/IO requester.
- Each requester uses a req/done handshake. The arbiter latches the winner's address, data and direction, drives the memory for one cycle, and returns read data with a one-cycle done pulse.
- Round-robin fairness, plus a bounded DMA burst lock.
- Provides cpu_stall so the CPU sequencer holds its step while waiting for memory.

Parameters:
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory data width.
- MAX_BURST, 4, maximum consecutive locked DMA accesses (legal range 1-15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (sampled on the rising clock edge; 0 = reset).
- cpu_req  in  1  CPU request; hold high with address/data stable until cpu_done.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_grant  out  1  CPU owns the memory (ACC and RESP states).
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data; valid with cpu_done, held until the next CPU read completes.
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational).
- dma_req  in  1  DMA request, same rules as cpu_req.
- dma_lock  in  1  request burst continuation after this access.
- dma_write  in  1  DMA direction.
- dma_addr  in  ADDR_WIDTH  DMA address.
- dma_wdata  in  DATA_WIDTH  DMA write data.
- dma_grant  out  1  DMA owns the memory.
- dma_done  out  1  one-cycle completion pulse.
- dma_rdata  out  DATA_WIDTH  DMA read data, same holding rule as cpu_rdata.
- mem_addr  out  ADDR_WIDTH  memory address (from latched register).
- mem_wdata  out  DATA_WIDTH  memory write data (from latched register).
- memory_read  out  1  read strobe.
- memory_write  out  1  write strobe.
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the same cycle as memory_read.

Behaviour:
- States: IDLE, CPU_ACC, CPU_RESP, DMA_ACC, DMA_RESP.
- Reset (reset==0 at an edge):
  - state=IDLE, last_owner=DMA (so the CPU wins the first tie).
  - lock_active=0, burst_cnt=0.
  - Latched addr/wdata/write = 0; cpu_rdata = dma_rdata = 0.
  - All outputs 0.
  - A reset mid-transaction aborts it: no done pulse, no further strobe.
- Arbitration in IDLE, evaluated in this order:
  - lock_active & dma_req -> DMA.
  - lock_active & ~dma_req -> clear lock_active and burst_cnt, then arbitrate normally in the same cycle.
  - Only one request -> that requester.
  - Both requesting -> the requester that is not last_owner.
- Transitions:
  - IDLE -> x_ACC on a grant; latch that requester's addr, wdata and write at the same edge.
  - x_ACC -> x_RESP unconditionally.
  - x_RESP -> IDLE unconditionally.
- ACC cycle:
  - memory_read = ~write_l, memory_write = write_l; mem_addr/mem_wdata driven from latched registers.
  - On a read, mem_rdata is captured into x_rdata at the end of the cycle.
- RESP cycle:
  - x_done=1 and memory strobes 0.
  - last_owner is updated at the RESP->IDLE edge.
- Strobes are 0 in IDLE and RESP.
- Latency: req high in cycle N (IDLE) -> ACC in N+1 -> done in N+2. A 3-cycle minimum per access; no back-to-back ACC.
- A requester must deassert req in the cycle after done, or it is treated as a new request.
- Burst lock, updated at the DMA_RESP edge:
  - If dma_lock==1 and burst_cnt+1 < MAX_BURST: lock_active=1 and burst_cnt increments.
  - Otherwise lock_active=0 and burst_cnt=0.
  - Consequences: at most MAX_BURST consecutive DMA accesses, and the CPU is never starved.
- Writes leave x_rdata unchanged.
- grant outputs equal the state decode.
- Requester inputs are ignored outside the latching edge, so address changes during ACC or RESP have no effect.

Decomposition:
- Shared package arb_pkg:
  - State encoding (3-bit constants).
  - OWNER_CPU/OWNER_DMA constants.
  - Default ADDR_WIDTH/DATA_WIDTH shared with the memory and the control unit.
- No sub-module: a single FSM with the latch, burst counter and rdata registers fits in one module (~180 lines).

Test Plan:
- Reset low for 2 cycles during CPU_ACC -> memory_read=0 next cycle; no cpu_done; all outputs 0; after release with only cpu_req, the first grant goes to the CPU.
- CPU read addr 0x10, memory returns 0x5A -> memory_read=1 and mem_addr=0x10 at N+1; cpu_done=1 and cpu_rdata=0x5A at N+2; cpu_stall high at N and N+1, low at N+2.
- cpu_req and dma_req asserted together and held (re-asserted after each done) -> grants alternate CPU, DMA, CPU, DMA; each access 3 cycles.
- DMA write addr 0x20 data 0xC3 -> memory_write=1, mem_addr=0x20, mem_wdata=0xC3 for exactly one cycle; dma_rdata unchanged.
- MAX_BURST=4, dma_lock=1, cpu_req held high -> exactly 4 consecutive DMA accesses, then the CPU is granted; lock_active=0 afterwards.
- DMA locked burst, dma_req dropped in IDLE while cpu_req is high -> lock cleared and the CPU is granted in that same IDLE cycle; burst_cnt=0.
